main_dec: RTL and testbench

MAIN_DEC -- requirements
Module: main_dec

---
 rtl/main_dec.sv | 119 +++++++++++
 tb/tb_main_dec.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/main_dec.sv
// Main instruction decoder: opcode -> registered 12-bit control word (+ illegal flag).
// Latency: 1 cycle from op to outputs.
// Backpressure: stall holds every output; flush loads an all-zero bubble and wins over stall.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset (clears all outputs at once)
//   op[5:0]                opcode field instr[31:26]
//   stall, flush           pipeline hold / bubble insert
//   regwrite .. aluop[3:0] registered control word
//                          {regwrite, regdst, alusrc, branch, memwrite, memtoreg,
//                           jump, zeroextend, aluop[3:0]}
//   illegal                registered "opcode not in decode table" flag
//
// Build option: define MAIN_DEC_ILLEGAL_EN to generate the illegal flag; without it,
// illegal is the constant 0 and nothing else changes.
module main_dec (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic       stall,
    input  logic       flush,
    output logic       regwrite,
    output logic       regdst,
    output logic       alusrc,
    output logic       branch,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       jump,
    output logic       zeroextend,
    output logic [3:0] aluop,
    output logic       illegal
);

    localparam logic [11:0] CW_RTYPE = 12'b1100_0000_1111;
    localparam logic [11:0] CW_J     = 12'b0000_0010_0000;
    localparam logic [11:0] CW_BEQ   = 12'b0001_0000_0001;
    localparam logic [11:0] CW_ADDI  = 12'b1010_0000_0000;
    localparam logic [11:0] CW_SLTI  = 12'b1010_0000_0010;
    localparam logic [11:0] CW_ANDI  = 12'b1010_0001_0100;
    localparam logic [11:0] CW_ORI   = 12'b1010_0001_0101;
    localparam logic [11:0] CW_XORI  = 12'b1010_0001_0110;
    localparam logic [11:0] CW_LUI   = 12'b1010_0001_0111;
    localparam logic [11:0] CW_LW    = 12'b1010_0100_0000;
    localparam logic [11:0] CW_SW    = 12'b0010_1000_0000;

    logic [11:0] ctrl_dec;
    logic [11:0] ctrl_d;
    logic [11:0] ctrl_q;

    // Pure combinational decode; unknown opcodes fall to the all-zero word so
    // they cannot cause a register or memory write.
    always_comb begin
        ctrl_dec = '0;
        case (op)
            6'd0:    ctrl_dec = CW_RTYPE;
            6'd2:    ctrl_dec = CW_J;
            6'd4:    ctrl_dec = CW_BEQ;
            6'd8:    ctrl_dec = CW_ADDI;
            6'd9:    ctrl_dec = CW_ADDI;
            6'd10:   ctrl_dec = CW_SLTI;
            6'd12:   ctrl_dec = CW_ANDI;
            6'd13:   ctrl_dec = CW_ORI;
            6'd14:   ctrl_dec = CW_XORI;
            6'd15:   ctrl_dec = CW_LUI;
            6'd35:   ctrl_dec = CW_LW;
            6'd43:   ctrl_dec = CW_SW;
            default: ctrl_dec = '0;
        endcase
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (flush) begin
            ctrl_d = '0;
        end else if (!stall) begin
            ctrl_d = ctrl_dec;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign {regwrite, regdst, alusrc, branch, memwrite, memtoreg,
            jump, zeroextend, aluop} = ctrl_q;

`ifdef MAIN_DEC_ILLEGAL_EN
    logic illegal_d;
    logic illegal_q;

    // Every listed opcode has a nonzero control word, so a zero decode
    // identifies exactly the opcodes outside the table.
    always_comb begin
        illegal_d = illegal_q;
        if (flush) begin
            illegal_d = 1'b0;
        end else if (!stall) begin
            illegal_d = (ctrl_dec == 12'd0);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_main_dec.sv
// Self-checking bench for main_dec: table of one-cycle vectors plus
// hand-written reset / async-reset sequences.
// Works with or without MAIN_DEC_ILLEGAL_EN defined.
module tb_main_dec;

    logic       clk;
    logic       resetn;
    logic [5:0] op;
    logic       stall;
    logic       flush;
    logic       regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, zeroextend;
    logic [3:0] aluop;
    logic       illegal;

    int checks = 0;
    int errors = 0;

`ifdef MAIN_DEC_ILLEGAL_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    main_dec dut (
        .clk        (clk),
        .resetn     (resetn),
        .op         (op),
        .stall      (stall),
        .flush      (flush),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .alusrc     (alusrc),
        .branch     (branch),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .jump       (jump),
        .zeroextend (zeroextend),
        .aluop      (aluop),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        stall;
        logic        flush;
        logic [11:0] exp_cw;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [5:0] o, logic s, logic f,
                                logic [11:0] cw, logic il);
        vec_t v;
        v.name = n; v.op = o; v.stall = s; v.flush = f; v.exp_cw = cw; v.exp_ill = il;
        return v;
    endfunction

    task automatic check(string name, logic [11:0] exp_cw, logic exp_ill);
        logic [11:0] cw;
        cw = {regwrite, regdst, alusrc, branch, memwrite, memtoreg,
              jump, zeroextend, aluop};
        checks++;
        if (cw !== exp_cw || illegal !== exp_ill) begin
            errors++;
            $display("FAIL %s: got cw=%b ill=%b, expected cw=%b ill=%b",
                     name, cw, illegal, exp_cw, exp_ill);
        end
    endtask

    initial begin
        // Directed vectors; each entry drives one cycle, expected values are
        // the outputs one rising edge later.
        vecs.push_back(mk("rtype",  6'd0,  0, 0, 12'b1100_0000_1111, 0));
        vecs.push_back(mk("j",      6'd2,  0, 0, 12'b0000_0010_0000, 0));
        vecs.push_back(mk("beq",    6'd4,  0, 0, 12'b0001_0000_0001, 0));
        vecs.push_back(mk("addi",   6'd8,  0, 0, 12'b1010_0000_0000, 0));
        vecs.push_back(mk("addiu",  6'd9,  0, 0, 12'b1010_0000_0000, 0));
        vecs.push_back(mk("slti",   6'd10, 0, 0, 12'b1010_0000_0010, 0));
        vecs.push_back(mk("andi",   6'd12, 0, 0, 12'b1010_0001_0100, 0));
        vecs.push_back(mk("ori",    6'd13, 0, 0, 12'b1010_0001_0101, 0));
        vecs.push_back(mk("xori",   6'd14, 0, 0, 12'b1010_0001_0110, 0));
        vecs.push_back(mk("lui",    6'd15, 0, 0, 12'b1010_0001_0111, 0));
        vecs.push_back(mk("lw",     6'd35, 0, 0, 12'b1010_0100_0000, 0));
        vecs.push_back(mk("sw",     6'd43, 0, 0, 12'b0010_1000_0000, 0));
        // Undefined opcodes
        vecs.push_back(mk("undef63",   6'd63, 0, 0, 12'h000, ILL));
        vecs.push_back(mk("undef63_stall", 6'd0, 1, 0, 12'h000, ILL));
        vecs.push_back(mk("undef63_flush", 6'd63, 0, 1, 12'h000, 0));
        vecs.push_back(mk("undef1",    6'd1,  0, 0, 12'h000, ILL));
        vecs.push_back(mk("undef3",    6'd3,  0, 0, 12'h000, ILL));
        vecs.push_back(mk("beq_after_undef", 6'd4, 0, 0, 12'b0001_0000_0001, 0));
        // Stall holds
        vecs.push_back(mk("stall_lw",   6'd35, 0, 0, 12'b1010_0100_0000, 0));
        vecs.push_back(mk("stall_hold", 6'd2,  1, 0, 12'b1010_0100_0000, 0));
        vecs.push_back(mk("stall_hold2",6'd63, 1, 0, 12'b1010_0100_0000, 0));
        vecs.push_back(mk("stall_rel",  6'd2,  0, 0, 12'b0000_0010_0000, 0));
        // Flush priority over stall
        vecs.push_back(mk("flush_slti", 6'd10, 0, 0, 12'b1010_0000_0010, 0));
        vecs.push_back(mk("flush_stall",6'd10, 1, 1, 12'h000, 0));
        vecs.push_back(mk("after_flush",6'd0,  0, 0, 12'b1100_0000_1111, 0));
        vecs.push_back(mk("flush_only", 6'd43, 0, 1, 12'h000, 0));

        // Reset with clock running
        resetn = 1'b0; op = 6'd0; stall = 1'b0; flush = 1'b0;
        #1;
        check("reset_immediate", 12'h000, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held_clocked", 12'h000, 0);

        // Release away from the edge; first edge loads op=0
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("first_after_reset", 12'b1100_0000_1111, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            op = vecs[i].op; stall = vecs[i].stall; flush = vecs[i].flush;
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].exp_cw, vecs[i].exp_ill);
        end

        // Async reset between edges while RTYPE word is held
        @(negedge clk);
        op = 6'd0; stall = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        check("pre_async_rtype", 12'b1100_0000_1111, 0);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("async_reset_clear", 12'h000, 0);
        // Reset overrides stall/flush and decode on following edges
        stall = 1'b1; flush = 1'b1; op = 6'd35;
        @(posedge clk); #1;
        check("reset_over_stall_flush", 12'h000, 0);

        // Undefined op held through reset must stay clean, then decode after release
        op = 6'd63; stall = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        check("reset_over_undef", 12'h000, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("undef_after_reset", 12'h000, ILL);
        @(negedge clk);
        op = 6'd13;
        @(posedge clk); #1;
        check("ori_after_reset", 12'b1010_0001_0101, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
